// File: rtl/bpu_pkg.sv
// Shared constants and types for the branch prediction unit: branch opcode,
// funct3 condition codes and the 2-bit saturating counter type.
package bpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  typedef logic [1:0] cnt_t;
  localparam cnt_t CNT_WNT = 2'b01;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; valid_funct flags funct3 codes
// that name a real conditional branch.
module branch_cmp
  import bpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            valid_funct
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    taken       = 1'b0;
    valid_funct = 1'b1;
    case (funct3)
      BEQ:     taken = (rs1 == rs2);
      BNE:     taken = (rs1 != rs2);
      BLT:     taken = (rs1_s <  rs2_s);
      BGE:     taken = (rs1_s >= rs2_s);
      BLTU:    taken = (rs1 <  rs2);
      BGEU:    taken = (rs1 >= rs2);
      default: valid_funct = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with execute-stage resolution and redirect.
// Optional statistics counters are built when BPU_STATS_EN is defined.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            e_valid,
  input  logic [6:0]      e_opcode,
  input  logic [2:0]      e_funct3,
  input  logic [XLEN-1:0] e_rs1,
  input  logic [XLEN-1:0] e_rs2,
  input  logic [XLEN-1:0] e_pc,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  function automatic cnt_t sat_cnt(input cnt_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  cnt_t             bht [BHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             unused_pc_bits;

  assign f_idx          = f_pc[IDX_W+1:2];
  assign e_idx          = e_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign f_pred_taken = bht[f_idx][1];

  // Stage p0: execute-stage resolution
  logic            cmp_taken_p0;
  logic            cmp_valid_p0;
  logic            resolve_p0;
  logic            taken_p0;
  logic            mis_p0;
  logic [XLEN-1:0] redir_p0;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1         (e_rs1),
    .rs2         (e_rs2),
    .funct3      (e_funct3),
    .taken       (cmp_taken_p0),
    .valid_funct (cmp_valid_p0)
  );

  assign resolve_p0 = e_valid && (e_opcode == OP_BRANCH) && cmp_valid_p0;
  assign taken_p0   = resolve_p0 && cmp_taken_p0;
  // Non-branches predicted taken fall out here as mispredicts to PC+4.
  assign mis_p0     = e_valid && (taken_p0 != e_pred_taken);
  assign redir_p0   = taken_p0 ? e_target : e_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_WNT;
    end else if (resolve_p0) begin
      bht[e_idx] <= sat_cnt(bht[e_idx], taken_p0);
    end
  end

  // Stage p1: registered redirect
  logic            mis_p1;
  logic [XLEN-1:0] redir_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_p1   <= 1'b0;
      redir_p1 <= '0;
    end else begin
      mis_p1 <= mis_p0;
      if (mis_p0) redir_p1 <= redir_p0;
    end
  end

  assign mispredict  = mis_p1;
  assign redirect_pc = redir_p1;

`ifdef BPU_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (resolve_p0) br_cnt_q   <= sat_inc32(br_cnt_q);
      if (mis_p0)     miss_cnt_q <= sat_inc32(miss_cnt_q);
    end
  end

  assign br_count   = br_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign br_count   = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit with a scoreboard queue for the
// registered redirect outputs.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        e_valid;
  logic [6:0]  e_opcode;
  logic [2:0]  e_funct3;
  logic [31:0] e_rs1, e_rs2, e_pc, e_target;
  logic        e_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count, miss_count;

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .f_pc         (f_pc),
    .f_pred_taken (f_pred_taken),
    .e_valid      (e_valid),
    .e_opcode     (e_opcode),
    .e_funct3     (e_funct3),
    .e_rs1        (e_rs1),
    .e_rs2        (e_rs2),
    .e_pc         (e_pc),
    .e_target     (e_target),
    .e_pred_taken (e_pred_taken),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .br_count     (br_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        br;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic        exp_fpred;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPA = 7'b0110011;

  vec_t vecs[14];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_br = 0;
  int   exp_miss = 0;

  function automatic vec_t mk(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input logic pred, input logic br, input logic mis,
                              input logic [31:0] redir, input logic fpred);
    vec_t v;
    v.vld = vld; v.op = op; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc;
    v.tgt = tgt; v.pred = pred; v.br = br; v.exp_mis = mis;
    v.exp_redir = redir; v.exp_fpred = fpred;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    e_valid = v.vld; e_opcode = v.op; e_funct3 = v.f3;
    e_rs1 = v.rs1; e_rs2 = v.rs2; e_pc = v.pc; e_target = v.tgt;
    e_pred_taken = v.pred; f_pc = v.pc;
    sb.push_back('{mis: v.exp_mis, redir: v.exp_redir});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, e.mis});
    chk({tag, "_redirect"}, redirect_pc, e.redir);
    chk({tag, "_fpred"}, {31'd0, f_pred_taken}, {31'd0, v.exp_fpred});
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; f_pc = 32'h100; e_valid = 1'b0; e_opcode = '0; e_funct3 = '0;
    e_rs1 = '0; e_rs2 = '0; e_pc = '0; e_target = '0; e_pred_taken = 1'b0;

    //        vld  op   f3      rs1           rs2           pc            tgt       pred br mis redir         fpred
    vecs[0]  = mk(1, OPB, 3'b000, 32'd5,        32'd5,        32'h100,      32'h80,   0, 1, 1, 32'h80,       1);
    vecs[1]  = mk(1, OPB, 3'b000, 32'd5,        32'd5,        32'h100,      32'h80,   1, 1, 0, 32'h80,       1);
    vecs[2]  = mk(1, OPB, 3'b000, 32'd5,        32'd5,        32'h100,      32'h80,   1, 1, 0, 32'h80,       1);
    vecs[3]  = mk(1, OPB, 3'b000, 32'd5,        32'd6,        32'h100,      32'h80,   1, 1, 1, 32'h104,      1);
    vecs[4]  = mk(1, OPB, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h204,      32'h300,  0, 1, 1, 32'h300,      1);
    vecs[5]  = mk(1, OPB, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h204,      32'h300,  0, 1, 0, 32'h300,      0);
    vecs[6]  = mk(1, OPA, 3'b000, 32'd0,        32'd0,        32'h200,      32'h900,  1, 0, 1, 32'h204,      1);
    vecs[7]  = mk(1, OPB, 3'b001, 32'd1,        32'd2,        32'h108,      32'h400,  0, 1, 1, 32'h400,      1);
    vecs[8]  = mk(0, OPB, 3'b001, 32'd3,        32'd3,        32'h108,      32'h400,  1, 0, 0, 32'h400,      1);
    vecs[9]  = mk(1, OPB, 3'b010, 32'd3,        32'd3,        32'h108,      32'h400,  0, 0, 0, 32'h400,      1);
    vecs[10] = mk(1, OPB, 3'b011, 32'd3,        32'd4,        32'h108,      32'h400,  1, 0, 1, 32'h10C,      1);
    vecs[11] = mk(1, OPB, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h10C,      32'h500,  1, 1, 0, 32'h10C,      1);
    vecs[12] = mk(1, OPB, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h10C,      32'h500,  1, 1, 1, 32'h110,      0);
    vecs[13] = mk(1, OPB, 3'b000, 32'd3,        32'd4,        32'hFFFFFFFC, 32'h600,  1, 1, 1, 32'h0,        0);

    #2;
    chk("rst_fpred", {31'd0, f_pred_taken}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      if (vecs[i].br) exp_br++;
      if (vecs[i].exp_mis) exp_miss++;
    end
`ifdef BPU_STATS_EN
    chk("br_count", br_count, 32'(exp_br));
    chk("miss_count", miss_count, 32'(exp_miss));
`else
    chk("br_count_tied", br_count, 32'd0);
    chk("miss_count_tied", miss_count, 32'd0);
`endif

    // Reset lands while a mispredicting branch is in execute.
    @(negedge clk);
    e_valid = 1'b1; e_opcode = OPB; e_funct3 = 3'b000; e_rs1 = 32'd7; e_rs2 = 32'd7;
    e_pc = 32'h114; e_target = 32'h600; e_pred_taken = 1'b0; f_pc = 32'h114;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("midrst_redirect", redirect_pc, 32'd0);
    chk("midrst_br_count", br_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
    @(negedge clk);
    e_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'(i * 4);
      #0.1;
      chk($sformatf("midrst_fpred_idx%0d", i), {31'd0, f_pred_taken}, 32'd0);
    end

    run_vec("post_rst_first", mk(1, OPB, 3'b000, 32'd5, 32'd5, 32'h100, 32'h80, 0, 1, 1, 32'h80, 1));
    run_vec("post_rst_idle",  mk(0, OPB, 3'b000, 32'd5, 32'd6, 32'h100, 32'h90, 1, 0, 0, 32'h80, 1));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
